ex_stage: RTL

Execute stage of the Simple-MIPS five-stage pipeline. It consumes the registered decode bundle from the ID/EX pipeline register: ALU op, ALU select, two register operands, extended immediate, write address and write enable. It produces the GPR write-back bundle for EX/MEM. It owns the HI/LO registers, a single-cycle multiplier and an iterative 32-cycle divider, and requests a pipeline stall while a divide is in progress.

---
 rtl/ex_stage.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU result path, HI/LO registers, single-cycle
// multiplier and a 32-iteration restoring divider that stalls the pipeline.
module ex_stage (
  input  logic        ex_clk,
  input  logic        ex_rst,
  input  logic [7:0]  ex_aluop_i,
  input  logic [2:0]  ex_alusel_i,
  input  logic [31:0] ex_rdata_1_i,
  input  logic [31:0] ex_rdata_2_i,
  input  logic [31:0] ex_ext_imm_i,
  input  logic [4:0]  ex_waddr_i,
  input  logic        ex_we_i,
  output logic [31:0] ex_wdata_o,
  output logic [4:0]  ex_waddr_o,
  output logic        ex_we_o,
  output logic        ex_stall_req_o,
  output logic [31:0] ex_hi_o,
  output logic [31:0] ex_lo_o
);

  localparam logic [2:0] SEL_NONE  = 3'd0;
  localparam logic [2:0] SEL_LOGIC = 3'd1;
  localparam logic [2:0] SEL_SHIFT = 3'd2;
  localparam logic [2:0] SEL_ARITH = 3'd3;
  localparam logic [2:0] SEL_MOVE  = 3'd4;

  localparam logic [7:0] OP_AND   = 8'h01;
  localparam logic [7:0] OP_OR    = 8'h02;
  localparam logic [7:0] OP_XOR   = 8'h03;
  localparam logic [7:0] OP_NOR   = 8'h04;
  localparam logic [7:0] OP_ANDI  = 8'h05;
  localparam logic [7:0] OP_ORI   = 8'h06;
  localparam logic [7:0] OP_XORI  = 8'h07;
  localparam logic [7:0] OP_LUI   = 8'h08;
  localparam logic [7:0] OP_SLL   = 8'h10;
  localparam logic [7:0] OP_SRL   = 8'h11;
  localparam logic [7:0] OP_SRA   = 8'h12;
  localparam logic [7:0] OP_ADDU  = 8'h20;
  localparam logic [7:0] OP_SUBU  = 8'h21;
  localparam logic [7:0] OP_SLT   = 8'h22;
  localparam logic [7:0] OP_SLTU  = 8'h23;
  localparam logic [7:0] OP_ADDIU = 8'h24;
  localparam logic [7:0] OP_MULT  = 8'h30;
  localparam logic [7:0] OP_MULTU = 8'h31;
  localparam logic [7:0] OP_DIV   = 8'h32;
  localparam logic [7:0] OP_DIVU  = 8'h33;
  localparam logic [7:0] OP_MFHI  = 8'h34;
  localparam logic [7:0] OP_MFLO  = 8'h35;
  localparam logic [7:0] OP_MTHI  = 8'h36;
  localparam logic [7:0] OP_MTLO  = 8'h37;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] div_r_q, div_r_d;
  logic [31:0] div_q_q, div_q_d;
  logic [31:0] div_d_q, div_d_d;
  logic        neg_q_q, neg_q_d;
  logic        neg_r_q, neg_r_d;
  logic        dz_q, dz_d;

  logic [31:0] a, b, imm;
  logic        is_div, div_signed;
  logic [31:0] res;
  logic        known;
  logic        stall;

  assign a          = ex_rdata_1_i;
  assign b          = ex_rdata_2_i;
  assign imm        = ex_ext_imm_i;
  assign is_div     = (ex_aluop_i == OP_DIV) || (ex_aluop_i == OP_DIVU);
  assign div_signed = (ex_aluop_i == OP_DIV);

  // Multiplier: sign- or zero-extend to 64 bits so the low 64 product bits are exact.
  logic signed [63:0] mul_a_s, mul_b_s, prod_s;
  logic        [63:0] prod_u;
  assign mul_a_s = {{32{a[31]}}, a};
  assign mul_b_s = {{32{b[31]}}, b};
  assign prod_s  = mul_a_s * mul_b_s;
  assign prod_u  = {32'd0, a} * {32'd0, b};

  logic signed [31:0] a_s, b_s;
  assign a_s = a;
  assign b_s = b;

  always_comb begin
    res   = 32'd0;
    known = 1'b0;
    case (ex_alusel_i)
      SEL_LOGIC: begin
        known = 1'b1;
        case (ex_aluop_i)
          OP_AND:  res = a & b;
          OP_OR:   res = a | b;
          OP_XOR:  res = a ^ b;
          OP_NOR:  res = ~(a | b);
          OP_ANDI: res = a & imm;
          OP_ORI:  res = a | imm;
          OP_XORI: res = a ^ imm;
          OP_LUI:  res = {imm[15:0], 16'h0000};
          default: known = 1'b0;
        endcase
      end
      SEL_SHIFT: begin
        known = 1'b1;
        case (ex_aluop_i)
          OP_SLL:  res = b << a[4:0];
          OP_SRL:  res = b >> a[4:0];
          OP_SRA:  res = b_s >>> a[4:0];
          default: known = 1'b0;
        endcase
      end
      SEL_ARITH: begin
        known = 1'b1;
        case (ex_aluop_i)
          OP_ADDU:  res = a + b;
          OP_SUBU:  res = a - b;
          OP_SLT:   res = {31'd0, (a_s < b_s)};
          OP_SLTU:  res = {31'd0, (a < b)};
          OP_ADDIU: res = a + imm;
          default:  known = 1'b0;
        endcase
      end
      SEL_MOVE: begin
        known = 1'b1;
        case (ex_aluop_i)
          OP_MFHI: res = hi_q;
          OP_MFLO: res = lo_q;
          OP_MTHI, OP_MTLO: res = 32'd0;
          default: known = 1'b0;
        endcase
      end
      SEL_NONE: begin
        known = (ex_aluop_i == OP_MULT) || (ex_aluop_i == OP_MULTU) || is_div;
      end
      default: known = 1'b0;
    endcase
  end

  assign stall = !ex_rst && (((state_q == IDLE) && is_div) || (state_q == BUSY));

  assign ex_stall_req_o = stall;
  assign ex_wdata_o     = (ex_rst || !known) ? 32'd0 : res;
  assign ex_waddr_o     = ex_waddr_i;
  assign ex_we_o        = ex_we_i && known && !stall && !ex_rst;
  assign ex_hi_o        = hi_q;
  assign ex_lo_o        = lo_q;

  // Divider datapath: one restoring step on the latched magnitudes.
  logic [32:0] r_shift, r_diff;
  assign r_shift = {div_r_q, div_q_q[31]};
  assign r_diff  = r_shift - {1'b0, div_d_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_r_d = div_r_q;
    div_q_d = div_q_q;
    div_d_d = div_d_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (is_div) begin
          if (b == 32'd0) begin
            dz_d    = 1'b1;
            div_q_d = a;
            state_d = DONE;
          end else begin
            dz_d    = 1'b0;
            div_r_d = 32'd0;
            div_q_d = (div_signed && a[31]) ? -a : a;
            div_d_d = (div_signed && b[31]) ? -b : b;
            neg_q_d = div_signed && (a[31] ^ b[31]);
            neg_r_d = div_signed && a[31];
            cnt_d   = 5'd0;
            state_d = BUSY;
          end
        end else begin
          case (ex_aluop_i)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_MTHI:  hi_d = a;
            OP_MTLO:  lo_d = a;
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (!r_diff[32]) begin
          div_r_d = r_diff[31:0];
          div_q_d = {div_q_q[30:0], 1'b1};
        end else begin
          div_r_d = r_shift[31:0];
          div_q_d = {div_q_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = DONE;
      end
      DONE: begin
        if (dz_q) begin
          lo_d = 32'hFFFF_FFFF;
          hi_d = div_q_q;
        end else begin
          lo_d = neg_q_q ? -div_q_q : div_q_q;
          hi_d = neg_r_q ? -div_r_q : div_r_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ex_clk) begin
    if (ex_rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Divider operand/partial-result registers carry no reset; they are loaded before use.
  always_ff @(posedge ex_clk) begin
    div_r_q <= div_r_d;
    div_q_q <= div_q_d;
    div_d_q <= div_d_d;
    neg_q_q <= neg_q_d;
    neg_r_q <= neg_r_d;
    dz_q    <= dz_d;
  end

endmodule
